// File: rtl/cnn_axis_pkg.sv
// ============================================================================
// Module   : cnn_axis_pkg
// Brief    : Shared types and helpers for the CNN AXI-Stream ingress/egress.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cnn_axis_pkg;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } frame_state_e;

  // Each FIFO entry carries data plus the sof and eol flags.
  localparam int FIFO_META_W = 2;

  function automatic int fifo_entry_w(input int data_w);
    return data_w + FIFO_META_W;
  endfunction

  // Ceiling log2, never less than 1 so it can size a counter directly.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_fwft_fifo.sv
// ============================================================================
// Module   : axis_fwft_fifo
// Brief    : First-word-fall-through circular FIFO with occupancy count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_fwft_fifo
  import cnn_axis_pkg::*;
#(
  parameter int DATA_W = 34,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr_en,
  input  logic [DATA_W-1:0]         i_wr_data,
  input  logic                      i_rd_en,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [clog2(DEPTH):0]     o_cnt
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_cnt;
  logic              w_push;
  logic              w_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == c_depth);
  assign o_cnt     = r_cnt;
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;
  // Head is forced to zero when empty so stale storage never leaks out.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/s00_axis_frame_rx.sv
// ============================================================================
// Module   : s00_axis_frame_rx
// Brief    : AXI-Stream frame ingress with geometry checking and FWFT buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module s00_axis_frame_rx
  import cnn_axis_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_S_AXIS_FIFO_DEPTH  = 16,
  parameter int IMG_WIDTH            = 28,
  parameter int IMG_HEIGHT           = 28
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TUSER,
  input  logic                              rd_en,
  output logic                              empty,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   data_out,
  output logic                              sof_out,
  output logic                              eol_out,
  output logic [clog2(C_S_AXIS_FIFO_DEPTH):0] fifo_cnt,
  output logic                              frame_done,
  output logic                              err_sof,
  output logic                              err_eol_early,
  output logic                              err_eol_late,
  output logic [15:0]                       drop_cnt,
  output logic [15:0]                       frame_cnt
);

  localparam int DW    = C_S_AXIS_TDATA_WIDTH;
  localparam int EW    = fifo_entry_w(DW);
  localparam int COL_W = clog2(IMG_WIDTH);
  localparam int ROW_W = clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] c_last_col = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] c_last_row = ROW_W'(IMG_HEIGHT - 1);

  frame_state_e     r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_frame_done;
  logic             r_err_sof;
  logic             r_err_eol_early;
  logic             r_err_eol_late;
  logic [15:0]      r_drop_cnt;
  logic [15:0]      r_frame_cnt;

  logic             w_full;
  logic             w_accept;
  logic             w_at_last_col;
  logic             w_last_row;
  logic             w_line_end;
  logic             w_write;
  logic             w_wr_eol;
  logic [EW-1:0]    w_wr_entry;
  logic [EW-1:0]    w_rd_entry;
  logic             w_unused_tstrb;

  assign w_unused_tstrb = ^S_AXIS_TSTRB;

  // Ready depends only on reset and the registered occupancy.
  assign S_AXIS_TREADY = !S_AXIS_ARESET && !w_full;
  assign w_accept      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_at_last_col = (r_col == c_last_col);
  assign w_last_row    = (r_row == c_last_row);
  assign w_line_end    = w_at_last_col || S_AXIS_TLAST;
  assign w_write       = w_accept && ((r_state == ACTIVE) || S_AXIS_TUSER);
  assign w_wr_eol      = (r_state == ACTIVE) && !S_AXIS_TUSER && w_line_end;
  assign w_wr_entry    = {S_AXIS_TUSER, w_wr_eol, S_AXIS_TDATA};

  axis_fwft_fifo #(
    .DATA_W (EW),
    .DEPTH  (C_S_AXIS_FIFO_DEPTH)
  ) u_fifo (
    .clk       (S_AXIS_ACLK),
    .rst       (S_AXIS_ARESET),
    .i_wr_en   (w_write),
    .i_wr_data (w_wr_entry),
    .i_rd_en   (rd_en),
    .o_rd_data (w_rd_entry),
    .o_empty   (empty),
    .o_full    (w_full),
    .o_cnt     (fifo_cnt)
  );

  assign sof_out  = w_rd_entry[EW-1];
  assign eol_out  = w_rd_entry[EW-2];
  assign data_out = w_rd_entry[DW-1:0];

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      r_state         <= WAIT_SOF;
      r_col           <= '0;
      r_row           <= '0;
      r_frame_done    <= 1'b0;
      r_err_sof       <= 1'b0;
      r_err_eol_early <= 1'b0;
      r_err_eol_late  <= 1'b0;
      r_drop_cnt      <= '0;
      r_frame_cnt     <= '0;
    end else begin
      r_frame_done    <= 1'b0;
      r_err_sof       <= 1'b0;
      r_err_eol_early <= 1'b0;
      r_err_eol_late  <= 1'b0;
      if (w_accept) begin
        case (r_state)
          WAIT_SOF: begin
            if (S_AXIS_TUSER) begin
              r_col   <= COL_W'(1);
              r_row   <= '0;
              r_state <= ACTIVE;
            end else if (r_drop_cnt != 16'hFFFF) begin
              r_drop_cnt <= r_drop_cnt + 16'd1;
            end
          end
          ACTIVE: begin
            // A stray start-of-frame abandons the current frame and restarts.
            if (S_AXIS_TUSER) begin
              r_err_sof <= 1'b1;
              r_col     <= COL_W'(1);
              r_row     <= '0;
            end else if (w_line_end) begin
              r_err_eol_early <= S_AXIS_TLAST && !w_at_last_col;
              r_err_eol_late  <= w_at_last_col && !S_AXIS_TLAST;
              r_col           <= '0;
              if (w_last_row) begin
                r_row        <= '0;
                r_frame_done <= 1'b1;
                r_frame_cnt  <= r_frame_cnt + 16'd1;
                r_state      <= WAIT_SOF;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
          default: r_state <= WAIT_SOF;
        endcase
      end
    end
  end

  assign frame_done    = r_frame_done;
  assign err_sof       = r_err_sof;
  assign err_eol_early = r_err_eol_early;
  assign err_eol_late  = r_err_eol_late;
  assign drop_cnt      = r_drop_cnt;
  assign frame_cnt     = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_s00_axis_frame_rx.sv
// ============================================================================
// Module   : tb_s00_axis_frame_rx
// Brief    : Directed self-checking bench, 4x2 frames through a 4-deep FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_s00_axis_frame_rx;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int W = 4;
  localparam int H = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tdata;
  logic [3:0]    tstrb;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          tuser;
  logic          rd_en;
  logic          empty;
  logic [DW-1:0] data_out;
  logic          sof_out;
  logic          eol_out;
  logic [2:0]    fifo_cnt;
  logic          frame_done;
  logic          err_sof;
  logic          err_eol_early;
  logic          err_eol_late;
  logic [15:0]   drop_cnt;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int errors = 0;

  s00_axis_frame_rx #(
    .C_S_AXIS_TDATA_WIDTH (DW),
    .C_S_AXIS_FIFO_DEPTH  (DEPTH),
    .IMG_WIDTH            (W),
    .IMG_HEIGHT           (H)
  ) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (rst),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TUSER  (tuser),
    .rd_en         (rd_en),
    .empty         (empty),
    .data_out      (data_out),
    .sof_out       (sof_out),
    .eol_out       (eol_out),
    .fifo_cnt      (fifo_cnt),
    .frame_done    (frame_done),
    .err_sof       (err_sof),
    .err_eol_early (err_eol_early),
    .err_eol_late  (err_eol_late),
    .drop_cnt      (drop_cnt),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic u, input logic l, input logic v);
    tdata  = d;
    tuser  = u;
    tlast  = l;
    tvalid = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd_en = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_en = 1'b0;
    tstrb = 4'hF;
    drive('0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %0b expected 0", tready); end
    checks++;
    if (empty !== 1'b1 || fifo_cnt !== 3'd0) begin
      errors++; $display("FAIL reset_fifo got empty=%0b cnt=%0d expected empty=1 cnt=0", empty, fifo_cnt);
    end
    checks++;
    if (data_out !== '0 || sof_out !== 1'b0 || eol_out !== 1'b0) begin
      errors++; $display("FAIL reset_head got %0h/%0b/%0b expected 0/0/0", data_out, sof_out, eol_out);
    end
    checks++;
    if ({frame_done, err_sof, err_eol_early, err_eol_late} !== 4'b0 || drop_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_status got pulses=%0b drop=%0d frames=%0d expected 0", {frame_done, err_sof, err_eol_early, err_eol_late}, drop_cnt, frame_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (tready !== 1'b1) begin errors++; $display("FAIL release_tready got %0b expected 1", tready); end
  endtask

  task automatic test_clean_frame();
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(32'h10 + i, (i == 0), (i == 3 || i == 7), 1'b1);
      tick();
      checks++;
      if (data_out !== 32'h10 + i || sof_out !== (i == 0) || eol_out !== (i == 3 || i == 7)) begin
        errors++; $display("FAIL clean_head[%0d] got %0h sof=%0b eol=%0b expected %0h sof=%0b eol=%0b", i, data_out, sof_out, eol_out, 32'h10 + i, (i == 0), (i == 3 || i == 7));
      end
      checks++;
      if (frame_done !== (i == 7) || {err_sof, err_eol_early, err_eol_late} !== 3'b0) begin
        errors++; $display("FAIL clean_pulses[%0d] got done=%0b errs=%0b expected done=%0b errs=0", i, frame_done, {err_sof, err_eol_early, err_eol_late}, (i == 7));
      end
    end
    drive('0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (empty !== 1'b1 || frame_cnt !== 16'd1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL clean_end got empty=%0b frames=%0d done=%0b expected 1/1/0", empty, frame_cnt, frame_done);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h20 + i, (i == 0), (i == 3), 1'b1);
      tick();
      checks++;
      if (fifo_cnt !== 3'(i + 1)) begin errors++; $display("FAIL bp_fill[%0d] got %0d expected %0d", i, fifo_cnt, i + 1); end
    end
    checks++;
    if (tready !== 1'b0) begin errors++; $display("FAIL bp_full_tready got %0b expected 0", tready); end
    drive(32'h24, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (fifo_cnt !== 3'd4 || tready !== 1'b0) begin
      errors++; $display("FAIL bp_stall got cnt=%0d ready=%0b expected 4/0", fifo_cnt, tready);
    end
    rd_en = 1'b1;
    tick();
    checks++;
    if (fifo_cnt !== 3'd3 || tready !== 1'b1 || data_out !== 32'h21) begin
      errors++; $display("FAIL bp_pop got cnt=%0d ready=%0b head=%0h expected 3/1/21", fifo_cnt, tready, data_out);
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (fifo_cnt !== 3'd4 || tready !== 1'b0) begin
      errors++; $display("FAIL bp_refill got cnt=%0d ready=%0b expected 4/0", fifo_cnt, tready);
    end
    drive('0, 1'b0, 1'b0, 1'b0);
    rd_en = 1'b1;
    tick();
    tick();
    checks++;
    if (fifo_cnt !== 3'd2 || data_out !== 32'h23) begin
      errors++; $display("FAIL bp_drain got cnt=%0d head=%0h expected 2/23", fifo_cnt, data_out);
    end
    drive(32'h25, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (fifo_cnt !== 3'd2 || data_out !== 32'h24) begin
      errors++; $display("FAIL bp_pushpop got cnt=%0d head=%0h expected 2/24", fifo_cnt, data_out);
    end
    drive('0, 1'b0, 1'b0, 1'b0);
    rd_en = 1'b0;
  endtask

  task automatic test_pre_frame_garbage();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(32'hA0 + i, 1'b0, 1'b0, 1'b1);
      tick();
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL garbage_empty[%0d] got %0b expected 1", i, empty); end
    end
    checks++;
    if (drop_cnt !== 16'd3) begin errors++; $display("FAIL garbage_drop got %0d expected 3", drop_cnt); end
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(32'h30 + i, (i == 0), (i == 3 || i == 7), 1'b1);
      tick();
      if (i == 0) begin
        checks++;
        if (data_out !== 32'h30 || sof_out !== 1'b1) begin
          errors++; $display("FAIL garbage_first got %0h sof=%0b expected 30 sof=1", data_out, sof_out);
        end
      end
    end
    drive('0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (frame_cnt !== 16'd1 || drop_cnt !== 16'd3 || empty !== 1'b1) begin
      errors++; $display("FAIL garbage_end got frames=%0d drop=%0d empty=%0b expected 1/3/1", frame_cnt, drop_cnt, empty);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_geometry();
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(32'h40 + i, (i == 0), (i == 1), 1'b1);
      tick();
      checks++;
      if (data_out !== 32'h40 + i || eol_out !== (i == 1 || i == 5)) begin
        errors++; $display("FAIL geom_head[%0d] got %0h eol=%0b expected %0h eol=%0b", i, data_out, eol_out, 32'h40 + i, (i == 1 || i == 5));
      end
      checks++;
      if (err_eol_early !== (i == 1) || err_eol_late !== (i == 5) || frame_done !== (i == 5)) begin
        errors++; $display("FAIL geom_pulses[%0d] got early=%0b late=%0b done=%0b expected %0b/%0b/%0b", i, err_eol_early, err_eol_late, frame_done, (i == 1), (i == 5), (i == 5));
      end
    end
    drive('0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (frame_cnt !== 16'd1 || err_eol_late !== 1'b0) begin
      errors++; $display("FAIL geom_end got frames=%0d late=%0b expected 1/0", frame_cnt, err_eol_late);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_mid_frame_sof();
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(32'h50 + i, (i == 0 || i == 5), (i == 3 || i == 8 || i == 12), 1'b1);
      tick();
      checks++;
      if (data_out !== 32'h50 + i || sof_out !== (i == 0 || i == 5) || eol_out !== (i == 3 || i == 8 || i == 12)) begin
        errors++; $display("FAIL msof_head[%0d] got %0h sof=%0b eol=%0b", i, data_out, sof_out, eol_out);
      end
      checks++;
      if (err_sof !== (i == 5) || frame_done !== (i == 12)) begin
        errors++; $display("FAIL msof_pulses[%0d] got err_sof=%0b done=%0b expected %0b/%0b", i, err_sof, frame_done, (i == 5), (i == 12));
      end
    end
    drive('0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (frame_cnt !== 16'd1) begin errors++; $display("FAIL msof_frames got %0d expected 1", frame_cnt); end
    rd_en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(32'h60 + i, (i == 0), 1'b0, 1'b1);
      tick();
    end
    drive('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fifo_cnt !== 3'd3) begin errors++; $display("FAIL areset_pre got %0d expected 3", fifo_cnt); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || fifo_cnt !== 3'd0 || tready !== 1'b0) begin
      errors++; $display("FAIL areset_now got empty=%0b cnt=%0d ready=%0b expected 1/0/0", empty, fifo_cnt, tready);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (tready !== 1'b1) begin errors++; $display("FAIL areset_release got %0b expected 1", tready); end
    drive(32'h66, 1'b0, 1'b0, 1'b1);
    tick();
    drive('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (drop_cnt !== 16'd1 || empty !== 1'b1 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL areset_wait_sof got drop=%0d empty=%0b frames=%0d expected 1/1/0", drop_cnt, empty, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_backpressure();
    test_pre_frame_garbage();
    test_geometry();
    test_mid_frame_sof();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
